// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter
//   Round-robin arbiter that shares one 16:1 mux between up to N_REQ requesters.
//   It drives the mux select S with the index of the current grantee and a
//   one-hot grant vector. A tenure lasts until the grantee asserts done, drops
//   its request, or has held the mux for MAX_HOLD cycles. When a tenure ends,
//   arbitration runs again on the same edge, so the next grantee follows
//   back-to-back with no idle cycle.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no grant active, gnt=0, busy=0; S keeps the last grantee index
//   GRANT | requester S owns the mux, gnt=1<<S, busy=1, hold_cnt counts tenure
//
// Ports
//   clk      in   1       rising-edge clock
//   rst_n    in   1       synchronous active-low reset
//   req      in   N_REQ   request vector, bit i = requester i wants the mux
//   done     in   1       current grantee finished (only looked at in GRANT)
//   S        out  SEL_W   mux select, index of the current grantee
//   gnt      out  N_REQ   one-hot grant, all zero when idle
//   busy     out  1       high while a grant is active
//   timeout  out  1       one-cycle pulse: previous tenure ended by MAX_HOLD
module mux_sel_arbiter #(
   parameter int N_REQ    = 16,
   parameter int SEL_W    = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
   output logic [SEL_W-1:0] S,
   output logic [N_REQ-1:0] gnt,
   output logic             busy,
   output logic             timeout
);

   localparam int HW = $clog2(MAX_HOLD + 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t           state, state_nxt;
   logic [SEL_W-1:0] ptr, ptr_nxt;
   logic [SEL_W-1:0] s_nxt;
   logic [N_REQ-1:0] gnt_nxt;
   logic             busy_nxt;
   logic             timeout_nxt;
   logic [HW-1:0]    hold_cnt, hold_nxt;

   logic             found;
   logic [SEL_W-1:0] win;
   logic [SEL_W-1:0] idx;
   logic             at_max;
   logic             release_now;

   // Search from ptr upward with wrap. Walking from the far end back toward
   // ptr lets the last hit be the highest-priority requester.
   always_comb begin
      found = 1'b0;
      win   = ptr;
      idx   = ptr;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         idx = ptr + SEL_W'(i);
         if (req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   assign at_max      = (hold_cnt == HW'(MAX_HOLD));
   assign release_now = done || !req[S] || at_max;

   always_comb begin
      state_nxt   = state;
      ptr_nxt     = ptr;
      s_nxt       = S;
      gnt_nxt     = gnt;
      busy_nxt    = busy;
      timeout_nxt = 1'b0;
      hold_nxt    = hold_cnt;
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt    = GRANT;
               s_nxt        = win;
               gnt_nxt      = '0;
               gnt_nxt[win] = 1'b1;
               busy_nxt     = 1'b1;
               hold_nxt     = HW'(1);
               ptr_nxt      = win + SEL_W'(1);
            end
         end
         GRANT: begin
            if (release_now) begin
               // done wins over a coincident tenure limit, so no pulse then.
               timeout_nxt = !done && req[S] && at_max;
               if (found) begin
                  s_nxt        = win;
                  gnt_nxt      = '0;
                  gnt_nxt[win] = 1'b1;
                  busy_nxt     = 1'b1;
                  hold_nxt     = HW'(1);
                  ptr_nxt      = win + SEL_W'(1);
               end else begin
                  state_nxt = IDLE;
                  gnt_nxt   = '0;
                  busy_nxt  = 1'b0;
                  hold_nxt  = '0;
               end
            end else begin
               hold_nxt = hold_cnt + HW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            busy_nxt  = 1'b0;
            hold_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= '0;
         S        <= '0;
         gnt      <= '0;
         busy     <= 1'b0;
         timeout  <= 1'b0;
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         S        <= s_nxt;
         gnt      <= gnt_nxt;
         busy     <= busy_nxt;
         timeout  <= timeout_nxt;
         hold_cnt <= hold_nxt;
      end
   end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter, built with a four-cycle tenure limit so that
// timeouts show up often. Each task drives one scenario and checks outputs
// against fixed values and against a cycle-level reference model of the
// arbitration rules.
module tb_mux_sel_arbiter;

   localparam int MH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] req = '0;
   logic        done = 1'b0;
   logic [3:0]  S;
   logic [15:0] gnt;
   logic        busy;
   logic        timeout;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   int m_s    = 0;
   int m_ptr  = 0;
   int m_hold = 0;
   bit m_busy = 0;
   bit m_to   = 0;

   mux_sel_arbiter #(.N_REQ(16), .SEL_W(4), .MAX_HOLD(MH)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .done(done),
      .S(S), .gnt(gnt), .busy(busy), .timeout(timeout)
   );

   always #5 clk = ~clk;

   function automatic int pick(input logic [15:0] r, input int p);
      for (int i = 0; i < 16; i++)
         if (r[(p + i) % 16]) return (p + i) % 16;
      return -1;
   endfunction

   function automatic logic [21:0] expect_vec();
      logic [15:0] g;
      g = m_busy ? (16'h0001 << m_s) : 16'h0000;
      return {m_s[3:0], g, m_busy, m_to};
   endfunction

   task automatic model_edge();
      int w;
      if (!rst_n) begin
         m_s = 0; m_ptr = 0; m_hold = 0; m_busy = 0; m_to = 0;
      end else if (!m_busy) begin
         m_to = 0;
         w = pick(req, m_ptr);
         if (w >= 0) begin
            m_s = w; m_busy = 1; m_hold = 1; m_ptr = (w + 1) % 16;
         end
      end else if (done || !req[m_s] || m_hold == MH) begin
         m_to = !done && req[m_s] && (m_hold == MH);
         w = pick(req, m_ptr);
         if (w >= 0) begin
            m_s = w; m_hold = 1; m_ptr = (w + 1) % 16;
         end else begin
            m_busy = 0; m_hold = 0;
         end
      end else begin
         m_hold++;
         m_to = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req = 16'hFFFF; done = 1'b0;
      tick(); tick();
      n_cmp++;
      if ({S, gnt, busy, timeout} !== 22'd0) begin
         n_err++;
         $display("FAIL reset_state: got S=%0d gnt=%h busy=%b to=%b, want all zero", S, gnt, busy, timeout);
      end
      rst_n = 1'b1;
      tick();
      n_cmp++;
      if (gnt !== 16'h0001 || S !== 4'd0 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL reset_first_grant: got S=%0d gnt=%h busy=%b, want S=0 gnt=0001 busy=1", S, gnt, busy);
      end
   endtask

   task automatic test_single_user();
      req = 16'h0000;
      tick();
      n_cmp++;
      if (busy !== 1'b0 || gnt !== 16'h0000) begin
         n_err++;
         $display("FAIL idle_after_drop: got gnt=%h busy=%b, want 0000/0", gnt, busy);
      end
      req = 16'h0020;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_cmp++;
         if (S !== 4'd5 || gnt !== 16'h0020 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_hold cycle %0d: got S=%0d gnt=%h busy=%b, want S=5 gnt=0020 busy=1", c, S, gnt, busy);
         end
      end
      done = 1'b1; req = 16'h0000;
      tick();
      done = 1'b0;
      n_cmp++;
      if (gnt !== 16'h0000 || busy !== 1'b0 || timeout !== 1'b0 || S !== 4'd5) begin
         n_err++;
         $display("FAIL single_release: got S=%0d gnt=%h busy=%b to=%b, want S=5 gnt=0 busy=0 to=0", S, gnt, busy, timeout);
      end
   endtask

   task automatic test_rotation();
      logic [3:0] prev;
      req = 16'h8001; done = 1'b1;
      tick();
      prev = S;
      n_cmp++;
      if ({S, gnt, busy, timeout} !== expect_vec()) begin
         n_err++;
         $display("FAIL rotation_start: got %h, want %h", {S, gnt, busy, timeout}, expect_vec());
      end
      for (int c = 0; c < 4; c++) begin
         tick();
         n_cmp++;
         if (busy !== 1'b1 || gnt === 16'h0000 || S === prev || !(S == 4'd0 || S == 4'd15)) begin
            n_err++;
            $display("FAIL rotation_alt cycle %0d: got S=%0d gnt=%h busy=%b prevS=%0d", c, S, gnt, busy, prev);
         end
         prev = S;
      end
      n_cmp++;
      if (S !== 4'd15) begin
         n_err++;
         $display("FAIL rotation_end: got S=%0d, want 15", S);
      end
      req = 16'h4001; done = 1'b0;
      tick();
      n_cmp++;
      if (S !== 4'd0 || gnt !== 16'h0001 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL wrap_search: got S=%0d gnt=%h busy=%b, want S=0 gnt=0001 busy=1", S, gnt, busy);
      end
      req = 16'h0000;
      tick();
   endtask

   task automatic test_timeout();
      req = 16'h0008; done = 1'b0;
      for (int c = 0; c < MH; c++) begin
         tick();
         n_cmp++;
         if (S !== 4'd3 || gnt !== 16'h0008 || timeout !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_hold cycle %0d: got S=%0d gnt=%h to=%b, want S=3 gnt=0008 to=0", c, S, gnt, timeout);
         end
      end
      tick();
      n_cmp++;
      if (S !== 4'd3 || gnt !== 16'h0008 || busy !== 1'b1 || timeout !== 1'b1) begin
         n_err++;
         $display("FAIL timeout_pulse: got S=%0d gnt=%h busy=%b to=%b, want S=3 gnt=0008 busy=1 to=1", S, gnt, busy, timeout);
      end
      req = 16'h0048;
      for (int c = 0; c < MH - 1; c++) begin
         tick();
         n_cmp++;
         if (S !== 4'd3 || timeout !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_second_hold cycle %0d: got S=%0d to=%b, want S=3 to=0", c, S, timeout);
         end
      end
      tick();
      n_cmp++;
      if (S !== 4'd6 || gnt !== 16'h0040 || timeout !== 1'b1) begin
         n_err++;
         $display("FAIL timeout_handover: got S=%0d gnt=%h to=%b, want S=6 gnt=0040 to=1", S, gnt, timeout);
      end
   endtask

   task automatic test_reset_mid_grant();
      req = 16'h0000;
      tick();
      req = 16'h0200;
      tick();
      n_cmp++;
      if (S !== 4'd9 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL mid_setup: got S=%0d busy=%b, want S=9 busy=1", S, busy);
      end
      rst_n = 1'b0;
      tick();
      n_cmp++;
      if ({S, gnt, busy, timeout} !== 22'd0) begin
         n_err++;
         $display("FAIL mid_reset: got S=%0d gnt=%h busy=%b to=%b, want all zero", S, gnt, busy, timeout);
      end
      rst_n = 1'b1; req = 16'h0202;
      tick();
      n_cmp++;
      if (S !== 4'd1 || gnt !== 16'h0002 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL mid_regrant: got S=%0d gnt=%h busy=%b, want S=1 gnt=0002 busy=1", S, gnt, busy);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         rst_n = ($urandom_range(0, 59) != 0);
         case ($urandom_range(0, 4))
            0:       req = 16'h0000;
            1:       req = 16'h0001 << $urandom_range(0, 15);
            2:       req = 16'($urandom) & 16'($urandom) & 16'($urandom);
            3:       req = req;
            default: req = 16'($urandom);
         endcase
         done = ($urandom_range(0, 3) == 0);
         tick();
         n_cmp++;
         if ({S, gnt, busy, timeout} !== expect_vec()) begin
            n_err++;
            $display("FAIL random cycle %0d: got S=%0d gnt=%h busy=%b to=%b, want %h", c, S, gnt, busy, timeout, expect_vec());
         end
         n_cmp++;
         if (busy ? (gnt !== (16'h0001 << S)) : (gnt !== 16'h0000)) begin
            n_err++;
            $display("FAIL onehot cycle %0d: got gnt=%h S=%0d busy=%b", c, gnt, S, busy);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_user();
      test_rotation();
      test_timeout();
      test_reset_mid_grant();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
